// File: rtl/icache_fetcher.sv
// Instruction fetch stage: PC register, direct-mapped one-word-per-line I-cache, single-outstanding
// memory read on miss. Define ICACHE_EN to instantiate the cache; otherwise every fetch goes to memory.
module icache_fetcher #(
  parameter int          ICACHE_LINES = 256,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  output logic        out_mem_ce,
  output logic [31:0] out_mem_addr,
  input  logic        in_mem_ce,
  input  logic [31:0] in_mem_data,
  input  logic        in_iq_full,
  output logic        out_inst_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        in_rob_misbranch,
  input  logic [31:0] in_rob_newpc
);

  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {S_FETCH, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic        mem_ce_q, mem_ce_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] opc_q, opc_d;

  logic        fill_we;
  logic        hit;
  logic [31:0] hit_word;
  logic        buf_match;

`ifdef ICACHE_EN
  logic [IDX_W-1:0]        pc_idx;
  logic [TAG_W-1:0]        pc_tag;
  logic [ICACHE_LINES-1:0] line_valid_q;
  logic [31:0]             line_data_q [ICACHE_LINES];
  logic [TAG_W-1:0]        line_tag_q  [ICACHE_LINES];

  assign pc_idx   = pc_q[IDX_W+1:2];
  assign pc_tag   = pc_q[31:IDX_W+2];
  assign hit      = line_valid_q[pc_idx] && (line_tag_q[pc_idx] == pc_tag);
  assign hit_word = line_data_q[pc_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_valid_q <= '0;
    end else if (fill_we) begin
      line_valid_q[pc_idx] <= 1'b1;
    end
  end

  // Payload arrays need no reset: a line is only read once its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      line_data_q[pc_idx] <= in_mem_data;
      line_tag_q[pc_idx]  <= pc_tag;
    end
  end
`else
  logic [IDX_W-1:0] unused_idx;
  logic             unused_fill;

  assign unused_idx  = pc_q[IDX_W+1:2];
  assign unused_fill = fill_we;
  assign hit         = 1'b0;
  assign hit_word    = 32'h0;
`endif

  assign buf_match = buf_valid_q && (buf_pc_q == pc_q);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    buf_pc_d     = buf_pc_q;
    buf_valid_d  = buf_valid_q;
    mem_ce_d     = mem_ce_q;
    mem_addr_d   = mem_addr_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    opc_d        = opc_q;
    fill_we      = 1'b0;
    if (rdy) begin
      mem_ce_d     = 1'b0;
      inst_valid_d = 1'b0;
      if (in_rob_misbranch) begin
        // Redirect wins over everything, including a response landing this cycle.
        pc_d        = in_rob_newpc;
        state_d     = S_FETCH;
        buf_valid_d = 1'b0;
      end else begin
        case (state_q)
          S_FETCH: begin
            if (hit || buf_match) begin
              if (!in_iq_full) begin
                inst_valid_d = 1'b1;
                inst_d       = hit ? hit_word : buf_q;
                opc_d        = pc_q;
                pc_d         = pc_q + 32'd4;
                buf_valid_d  = 1'b0;
              end
            end else begin
              mem_ce_d   = 1'b1;
              mem_addr_d = pc_q;
              state_d    = S_WAIT;
            end
          end
          S_WAIT: begin
            if (in_mem_ce) begin
              buf_d       = in_mem_data;
              buf_pc_d    = pc_q;
              buf_valid_d = 1'b1;
              fill_we     = 1'b1;
              state_d     = S_FETCH;
            end
          end
          default: state_d = S_FETCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      buf_q        <= 32'h0;
      buf_pc_q     <= 32'h0;
      buf_valid_q  <= 1'b0;
      mem_ce_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      opc_q        <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_q        <= buf_d;
      buf_pc_q     <= buf_pc_d;
      buf_valid_q  <= buf_valid_d;
      mem_ce_q     <= mem_ce_d;
      mem_addr_q   <= mem_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      opc_q        <= opc_d;
    end
  end

  assign out_mem_ce     = mem_ce_q;
  assign out_mem_addr   = mem_addr_q;
  assign out_inst_valid = inst_valid_q;
  assign out_inst       = inst_q;
  assign out_pc         = opc_q;

endmodule

// File: tb/tb_icache_fetcher.sv
// Directed bench for icache_fetcher: reset, miss/hit, backpressure, conflict eviction, redirects.
// Expectations branch on ICACHE_EN where cached and uncached builds differ.
module tb_icache_fetcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        out_mem_ce;
  logic [31:0] out_mem_addr;
  logic        in_mem_ce = 1'b0;
  logic [31:0] in_mem_data = 32'h0;
  logic        in_iq_full = 1'b0;
  logic        out_inst_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        in_rob_misbranch = 1'b0;
  logic [31:0] in_rob_newpc = 32'h0;

  int checks = 0;
  int errors = 0;

  icache_fetcher dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rdy              (rdy),
    .out_mem_ce       (out_mem_ce),
    .out_mem_addr     (out_mem_addr),
    .in_mem_ce        (in_mem_ce),
    .in_mem_data      (in_mem_data),
    .in_iq_full       (in_iq_full),
    .out_inst_valid   (out_inst_valid),
    .out_inst         (out_inst),
    .out_pc           (out_pc),
    .in_rob_misbranch (in_rob_misbranch),
    .in_rob_newpc     (in_rob_newpc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr);
    int n = 0;
    step();
    while (!out_mem_ce && n < 20) begin
      step();
      n++;
    end
    check({tag, "_ce"}, {31'h0, out_mem_ce}, 32'h1);
    check({tag, "_addr"}, out_mem_addr, addr);
  endtask

  task automatic respond(input logic [31:0] data);
    in_mem_ce   = 1'b1;
    in_mem_data = data;
    step();
    in_mem_ce   = 1'b0;
    in_mem_data = 32'h0;
  endtask

  task automatic expect_inst(input string tag, input logic [31:0] inst, input logic [31:0] pc);
    step();
    check({tag, "_valid"}, {31'h0, out_inst_valid}, 32'h1);
    check({tag, "_inst"}, out_inst, inst);
    check({tag, "_pc"}, out_pc, pc);
  endtask

  task automatic redirect(input logic [31:0] newpc);
    in_rob_misbranch = 1'b1;
    in_rob_newpc     = newpc;
    step();
    in_rob_misbranch = 1'b0;
    in_rob_newpc     = 32'h0;
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_ce", {31'h0, out_mem_ce}, 32'h0);
    check("rst_addr", out_mem_addr, 32'h0);
    check("rst_valid", {31'h0, out_inst_valid}, 32'h0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    rst_n = 1'b1;
    wait_req("first_req", 32'h0);

    // Cold miss, then a rdy stall keeps the pulse visible
    respond(32'h00500093);
    expect_inst("cold", 32'h00500093, 32'h0);
    rdy = 1'b0;
    step();
    check("stall_valid_held", {31'h0, out_inst_valid}, 32'h1);
    check("stall_no_req", {31'h0, out_mem_ce}, 32'h0);
    rdy = 1'b1;
    wait_req("req4", 32'h4);
    check("req4_valid_cleared", {31'h0, out_inst_valid}, 32'h0);

    // Loop back to 0: hit with cache, new request without
    redirect(32'h0);
`ifdef ICACHE_EN
    step();
    check("hit_no_req", {31'h0, out_mem_ce}, 32'h0);
    check("hit_valid", {31'h0, out_inst_valid}, 32'h1);
    check("hit_inst", out_inst, 32'h00500093);
    check("hit_pc", out_pc, 32'h0);
`else
    wait_req("nocache_req0", 32'h0);
    respond(32'h00500093);
    expect_inst("nocache_refetch", 32'h00500093, 32'h0);
`endif
    wait_req("req4b", 32'h4);

    // Backpressure with a buffered word
    in_iq_full = 1'b1;
    respond(32'h00A00113);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp%0d_valid", i), {31'h0, out_inst_valid}, 32'h0);
      check($sformatf("bp%0d_ce", i), {31'h0, out_mem_ce}, 32'h0);
    end
    in_iq_full = 1'b0;
    expect_inst("bp_release", 32'h00A00113, 32'h4);
    wait_req("req8", 32'h8);

    // Conflict: 0x400 maps to line 0 and evicts 0x0
    redirect(32'h400);
    wait_req("req400", 32'h400);
    respond(32'h00100073);
    expect_inst("conf400", 32'h00100073, 32'h400);
    wait_req("req404", 32'h404);
    redirect(32'h0);
    step();
    check("evict_ce", {31'h0, out_mem_ce}, 32'h1);
    check("evict_addr", out_mem_addr, 32'h0);
    check("evict_valid", {31'h0, out_inst_valid}, 32'h0);
    respond(32'h00500093);
    expect_inst("refill0", 32'h00500093, 32'h0);
    wait_req("req4c", 32'h4);

    // Redirect during WAIT
    redirect(32'h80);
    check("redir_wait_ce", {31'h0, out_mem_ce}, 32'h0);
    check("redir_wait_valid", {31'h0, out_inst_valid}, 32'h0);
    wait_req("req80", 32'h80);

    // Redirect coincident with response: response discarded
    in_mem_ce   = 1'b1;
    in_mem_data = 32'hBADBAD00;
    redirect(32'h100);
    in_mem_ce   = 1'b0;
    in_mem_data = 32'h0;
    check("redir_resp_valid", {31'h0, out_inst_valid}, 32'h0);
    wait_req("req100", 32'h100);
    check("req100_valid", {31'h0, out_inst_valid}, 32'h0);
    respond(32'h00000013);
    expect_inst("inst100", 32'h00000013, 32'h100);
    wait_req("req104", 32'h104);
    redirect(32'h80);
    wait_req("req80_not_cached", 32'h80);

    // Async reset mid-WAIT
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ce", {31'h0, out_mem_ce}, 32'h0);
    check("arst_addr", out_mem_addr, 32'h0);
    check("arst_valid", {31'h0, out_inst_valid}, 32'h0);
    check("arst_inst", out_inst, 32'h0);
    check("arst_pc", out_pc, 32'h0);
    step();
    rst_n = 1'b1;
    wait_req("post_rst_req", 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
